// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings shared by the pipelined barrel shifter
package shifter_pkg;
    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] MODE_SLL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SRL = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SRA = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;
endpackage

// File: rtl/multifunction_shifter_pipe_stage.sv
// shift_stage: one power-of-two shift/rotate step plus its pipeline register
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_sign,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    output logic              out_sign,
    output logic [WIDTH-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode,
    output logic [AMT_W-1:0]  out_amt
);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] shifted;
    // Bit 0 of the remaining amount selects this stage; pass-through modes ignore it
    always_comb begin
        fill    = ~({WIDTH{1'b1}} >> SHIFT) & {WIDTH{in_sign}};
        shifted = !in_amt[0]           ? in_data :
                  in_mode == MODE_SLL  ? in_data << SHIFT :
                  in_mode == MODE_SRL  ? in_data >> SHIFT :
                  in_mode == MODE_SRA  ? (in_data >> SHIFT) | fill :
                  in_mode == MODE_ROL  ? (in_data << SHIFT) | (in_data >> (WIDTH - SHIFT)) :
                  in_mode == MODE_ROR  ? (in_data >> SHIFT) | (in_data << (WIDTH - SHIFT)) :
                  in_data;
    end
    // Stage register: loads on the global advance, consumed amount bit is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            out_amt   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_sign  <= in_sign;
            out_data  <= shifted;
            out_mode  <= in_mode;
            out_amt   <= in_amt >> 1;
        end
    end
endmodule

// File: rtl/multifunction_shifter_pipe.sv
// multifunction_shifter_pipe: log2(WIDTH)-stage pipelined shift/rotate unit with valid/ready
module multifunction_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_y,
    output logic              out_zero
);
    logic              valid_s [AMT_W+1];
    logic              sign_s  [AMT_W+1];
    logic [WIDTH-1:0]  data_s  [AMT_W+1];
    logic [MODE_W-1:0] mode_s  [AMT_W+1];
    logic [AMT_W-1:0]  amt_s   [AMT_W+1];
    logic              advance;
    logic              unused_tail;

    // The whole pipe moves together; it only freezes when a finished result is not taken
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rst;
    assign valid_s[0] = in_valid;
    assign sign_s[0]  = in_a[WIDTH-1];
    assign data_s[0]  = in_a;
    assign mode_s[0]  = in_mode;
    assign amt_s[0]   = in_amt;
    assign out_valid = valid_s[AMT_W];
    assign out_y     = data_s[AMT_W];
    assign out_zero  = out_y == '0;
    assign unused_tail = ^{sign_s[AMT_W], mode_s[AMT_W], amt_s[AMT_W]};

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k),
            .AMT_W(AMT_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .in_valid (valid_s[k]),
            .in_sign  (sign_s[k]),
            .in_data  (data_s[k]),
            .in_mode  (mode_s[k]),
            .in_amt   (amt_s[k]),
            .out_valid(valid_s[k+1]),
            .out_sign (sign_s[k+1]),
            .out_data (data_s[k+1]),
            .out_mode (mode_s[k+1]),
            .out_amt  (amt_s[k+1])
        );
    end
endmodule

// File: tb/tb_multifunction_shifter_pipe.sv
// tb_multifunction_shifter_pipe: directed WIDTH=8 and random WIDTH=32 checks against a bitwise model
module tb_multifunction_shifter_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       v8 = 1'b0, r8, ov8, or8 = 1'b1, z8;
    logic [7:0] a8 = '0, y8;
    logic [2:0] amt8 = '0, m8 = '0;
    logic        v32 = 1'b0, r32, ov32, or32 = 1'b1, z32;
    logic [31:0] a32 = '0, y32;
    logic [4:0]  amt32 = '0;
    logic [2:0]  m32 = '0;

    multifunction_shifter_pipe #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_amt(amt8),
        .in_mode(m8), .out_valid(ov8), .out_ready(or8), .out_y(y8), .out_zero(z8)
    );
    multifunction_shifter_pipe #(.WIDTH(32)) d32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_amt(amt32),
        .in_mode(m32), .out_valid(ov32), .out_ready(or32), .out_y(y32), .out_zero(z32)
    );

    // Result bit i is picked straight from the operand by index arithmetic
    function automatic logic [31:0] model(input logic [31:0] a, input int amt, input logic [2:0] m, input int w);
        logic [31:0] y = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'd0: if (i >= amt) y[i] = a[i-amt];
                3'd1: if (i + amt < w) y[i] = a[i+amt];
                3'd2: y[i] = (i + amt < w) ? a[i+amt] : a[w-1];
                3'd3: y[i] = a[(i - amt + w) % w];
                3'd4: y[i] = a[(i + amt) % w];
                default: y[i] = a[i];
            endcase
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    logic [31:0] q8[$];
    logic [31:0] q32[$];
    int cnt8 = 0, cnt32 = 0;
    logic stall8 = 1'b0, stall32 = 1'b0;
    logic [7:0] hold8 = '0;
    logic [31:0] hold32 = '0;

    // Scoreboard for the 8-bit unit: push on accept, compare and pop on output transfer
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            stall8 <= 1'b0;
        end else begin
            if (stall8) begin
                chk("stall8_valid", 32'(ov8), 32'd1);
                chk("stall8_y", 32'(y8), 32'(hold8));
            end
            if (ov8 && !or8) chk("noaccept8", 32'(r8), 32'd0);
            if (ov8) begin
                if (q8.size() == 0) chk("spurious8", 32'(ov8), 32'd0);
                else begin
                    chk("y8", 32'(y8), q8[0]);
                    chk("zero8", 32'(z8), 32'(q8[0] == 0));
                    if (or8) begin
                        void'(q8.pop_front());
                        cnt8++;
                    end
                end
            end
            if (v8 && r8) q8.push_back(model({24'b0, a8}, int'(amt8), m8, 8));
            stall8 <= ov8 && !or8;
            hold8 <= y8;
        end
    end

    // Same scoreboard for the 32-bit unit
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            stall32 <= 1'b0;
        end else begin
            if (stall32) begin
                chk("stall32_valid", 32'(ov32), 32'd1);
                chk("stall32_y", y32, hold32);
            end
            if (ov32 && !or32) chk("noaccept32", 32'(r32), 32'd0);
            if (ov32) begin
                if (q32.size() == 0) chk("spurious32", 32'(ov32), 32'd0);
                else begin
                    chk("y32", y32, q32[0]);
                    chk("zero32", 32'(z32), 32'(q32[0] == 0));
                    if (or32) begin
                        void'(q32.pop_front());
                        cnt32++;
                    end
                end
            end
            if (v32 && r32) q32.push_back(model(a32, int'(amt32), m32, 32));
            stall32 <= ov32 && !or32;
            hold32 <= y32;
        end
    end

    task automatic send8(input logic [7:0] a, input logic [2:0] amt, input logic [2:0] m);
        int n = 0;
        a8 = a; amt8 = amt; m8 = m; v8 = 1'b1;
        @(negedge clk);
        while (!r8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout8", 32'(r8), 32'd1);
        @(posedge clk);
        #1 v8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [4:0] amt, input logic [2:0] m);
        int n = 0;
        a32 = a; amt32 = amt; m32 = m; v32 = 1'b1;
        @(negedge clk);
        while (!r32 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("accept_timeout32", 32'(r32), 32'd1);
        @(posedge clk);
        #1 v32 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", 32'(q8.size()), 32'd0);
    endtask

    task automatic drain32();
        int n = 0;
        while (q32.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain32", 32'(q32.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    logic done = 1'b0;
    int c0;

    initial begin
        chk("pin_sll06", model(32'h06, 1, 3'd0, 8), 32'h0C);
        chk("pin_sll81", model(32'h81, 1, 3'd0, 8), 32'h02);
        chk("pin_srl81", model(32'h81, 1, 3'd1, 8), 32'h40);
        chk("pin_sra81", model(32'h81, 1, 3'd2, 8), 32'hC0);
        chk("pin_rol81", model(32'h81, 1, 3'd3, 8), 32'h03);
        chk("pin_ror81", model(32'h81, 1, 3'd4, 8), 32'hC0);
        chk("pin_pass81", model(32'h81, 1, 3'd6, 8), 32'h81);
        chk("pin_sra80", model(32'h80, 7, 3'd2, 8), 32'hFF);
        chk("pin_sll01", model(32'h01, 7, 3'd0, 8), 32'h80);
        chk("pin_srl01", model(32'h01, 1, 3'd1, 8), 32'h00);
        chk("pin_ror32", model(32'h1, 1, 3'd4, 32), 32'h8000_0000);
        chk("pin_sra32", model(32'h8000_0000, 31, 3'd2, 32), 32'hFFFF_FFFF);

        #12;
        chk("rst_valid", 32'(ov8), 32'd0);
        chk("rst_y", 32'(y8), 32'd0);
        chk("rst_zero", 32'(z8), 32'd1);
        chk("rst_ready", 32'(r8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send8(8'h06, 3'd1, 3'd0);
        @(negedge clk); chk("lat_c1", 32'(ov8), 32'd0);
        @(negedge clk); chk("lat_c2", 32'(ov8), 32'd0);
        @(negedge clk);
        chk("lat_c3_valid", 32'(ov8), 32'd1);
        chk("lat_c3_y", 32'(y8), 32'h0C);
        chk("lat_c3_zero", 32'(z8), 32'd0);
        drain8();

        @(posedge clk); #1;
        for (int m = 0; m < 8; m++) send8(8'h81, 3'd1, 3'(m));
        send8(8'h80, 3'd7, 3'd2);
        send8(8'h01, 3'd7, 3'd0);
        send8(8'h01, 3'd1, 3'd1);
        for (int m = 0; m < 8; m++) send8(8'hA5, 3'd0, 3'(m));
        drain8();

        @(posedge clk); #1;
        c0 = cnt8;
        fork
            begin
                for (int i = 0; i < 8; i++) send8(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
            begin
                repeat (4) @(posedge clk);
                #1 or8 = 1'b0;
                @(negedge clk);
                chk("in_ready_drop", 32'(r8), 32'd0);
                repeat (4) @(posedge clk);
                #1 or8 = 1'b1;
            end
        join
        drain8();
        chk("stream_count", 32'(cnt8 - c0), 32'd8);

        @(posedge clk); #1;
        send8(8'h11, 3'd1, 3'd0);
        send8(8'h22, 3'd2, 3'd3);
        send8(8'h33, 3'd3, 3'd4);
        rst = 1'b1;
        #1;
        chk("flush_valid", 32'(ov8), 32'd0);
        chk("flush_ready", 32'(r8), 32'd0);
        chk("flush_zero", 32'(z8), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_rst", 32'(r8), 32'd1);
        c0 = cnt8;
        send8(8'h5A, 3'd4, 3'd3);
        repeat (6) @(negedge clk);
        chk("after_rst_count", 32'(cnt8 - c0), 32'd1);
        drain8();

        @(posedge clk); #1;
        c0 = cnt32;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send32($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 or32 = ($urandom_range(0, 3) != 0);
                end
                or32 = 1'b1;
            end
        join
        drain32();
        chk("random_count", 32'(cnt32 - c0), 32'd10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
